// File: rtl/pipelined_array_multiplier_n.sv
// Pipelined WIDTH x WIDTH carry-save array multiplier with a valid tag, a global stall enable and a 2*WIDTH product.
// Optional macro SIGNED_MODE_EN adds port tc and per-operation Baugh-Wooley two's-complement mode.
module pipelined_array_multiplier_n #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_MODE_EN
    input  logic                 tc,
`endif
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   p
);

    localparam int PW = 2 * WIDTH;

`ifdef SIGNED_MODE_EN
    // Baugh-Wooley correction: +2^WIDTH + 2^(2*WIDTH-1), injected as the initial carry vector.
    localparam logic [PW-1:0] BW_CORR = {{(WIDTH-1){1'b0}}, 1'b1, {WIDTH{1'b0}}}
                                      | {1'b1, {(PW-1){1'b0}}};
`endif

    // Partial-product row k, aligned to product weight.
    function automatic logic [PW-1:0] pp_row(
        input logic [WIDTH-1:0] op_a,
        input logic             b_bit,
        input int               k
`ifdef SIGNED_MODE_EN
        , input logic           inv
`endif
    );
        logic [WIDTH-1:0] row;
        logic [PW-1:0]    ext;
        row = op_a & {WIDTH{b_bit}};
`ifdef SIGNED_MODE_EN
        if (inv) begin
            if (k == WIDTH - 1) begin
                row = row ^ {1'b0, {(WIDTH-1){1'b1}}};
            end else begin
                row = row ^ {1'b1, {(WIDTH-1){1'b0}}};
            end
        end else begin
            row = row;
        end
`endif
        ext = {{WIDTH{1'b0}}, row};
        return ext << k;
    endfunction

    logic [WIDTH-1:0] a_q [0:WIDTH-2];
    logic [WIDTH-1:0] b_q [0:WIDTH-2];
    logic [WIDTH-1:0] v_q;
`ifdef SIGNED_MODE_EN
    logic [WIDTH-2:0] tc_q;
`endif
    logic [PW-1:0]    s_q [1:WIDTH-1];
    logic [PW-1:0]    c_q [1:WIDTH-1];
    logic [PW-1:0]    s_d [1:WIDTH-1];
    logic [PW-1:0]    c_d [1:WIDTH-1];
    logic             out_valid_q;
    logic [PW-1:0]    p_q;

    genvar k;
    generate
        for (k = 1; k < WIDTH; k++) begin : g_csa
            logic [PW-1:0] acc_s;
            logic [PW-1:0] car_s;
            logic [PW-1:0] row_s;
            if (k == 1) begin : g_first
`ifdef SIGNED_MODE_EN
                assign acc_s = pp_row(a_q[0], b_q[0][0], 0, tc_q[0]);
                assign car_s = tc_q[0] ? BW_CORR : {PW{1'b0}};
`else
                assign acc_s = pp_row(a_q[0], b_q[0][0], 0);
                assign car_s = {PW{1'b0}};
`endif
            end else begin : g_next
                assign acc_s = s_q[k-1];
                assign car_s = c_q[k-1];
            end
`ifdef SIGNED_MODE_EN
            assign row_s = pp_row(a_q[k-1], b_q[k-1][k], k, tc_q[k-1]);
`else
            assign row_s = pp_row(a_q[k-1], b_q[k-1][k], k);
`endif
            // 3:2 compression; the carry out of the top bit is beyond the product width.
            assign s_d[k] = acc_s ^ car_s ^ row_s;
            assign c_d[k] = ((acc_s & car_s) | (acc_s & row_s) | (car_s & row_s)) << 1;
        end
    endgenerate

    // Pipeline registers: reset clears everything, en=0 freezes every stage including p.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i <= WIDTH - 2; i++) begin
                a_q[i] <= {WIDTH{1'b0}};
                b_q[i] <= {WIDTH{1'b0}};
            end
            for (int i = 1; i <= WIDTH - 1; i++) begin
                s_q[i] <= {PW{1'b0}};
                c_q[i] <= {PW{1'b0}};
            end
            v_q         <= {WIDTH{1'b0}};
`ifdef SIGNED_MODE_EN
            tc_q        <= {(WIDTH-1){1'b0}};
`endif
            out_valid_q <= 1'b0;
            p_q         <= {PW{1'b0}};
        end else if (en) begin
            a_q[0] <= a;
            b_q[0] <= b;
            v_q[0] <= in_valid;
`ifdef SIGNED_MODE_EN
            tc_q[0] <= tc;
            for (int i = 1; i <= WIDTH - 2; i++) begin
                tc_q[i] <= tc_q[i-1];
            end
`endif
            for (int i = 1; i <= WIDTH - 2; i++) begin
                a_q[i] <= a_q[i-1];
                b_q[i] <= b_q[i-1];
            end
            for (int i = 1; i <= WIDTH - 1; i++) begin
                v_q[i] <= v_q[i-1];
                s_q[i] <= s_d[i];
                c_q[i] <= c_d[i];
            end
            out_valid_q <= v_q[WIDTH-1];
            if (v_q[WIDTH-1]) begin
                p_q <= s_q[WIDTH-1] + c_q[WIDTH-1];
            end else begin
                p_q <= p_q;
            end
        end else begin
            out_valid_q <= out_valid_q;
            p_q         <= p_q;
        end
    end

    assign out_valid = out_valid_q;
    assign p         = p_q;

endmodule

// File: tb/tb_pipelined_array_multiplier_n.sv
// Scoreboard bench for pipelined_array_multiplier_n (WIDTH=4): stimulus pushes expected products,
// a monitor pops and checks value and arrival edge. Signed vectors are used when SIGNED_MODE_EN is defined.
module tb_pipelined_array_multiplier_n;

    localparam int W   = 4;
    localparam int LAT = W + 1;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           en = 1'b0;
    logic           in_valid = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           tc = 1'b0;
    logic           out_valid;
    logic [2*W-1:0] p;

    exp_t q[$];
    int   en_edges = 0;
    int   chk_cnt = 0;
    int   pass_cnt = 0;

    pipelined_array_multiplier_n #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
`ifdef SIGNED_MODE_EN
        .tc        (tc),
`endif
        .out_valid (out_valid),
        .p         (p)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus driven at negedge; a real enabled op queues its hand-computed product.
    task automatic cyc(input logic e, input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic t, input logic [2*W-1:0] expp);
        exp_t it;
        @(negedge clk);
        en = e; in_valid = v; a = av; b = bv; tc = t;
        if (e && v && !rst) begin
            it.prod = expp;
            it.due  = en_edges + LAT;
            q.push_back(it);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            idle(1);
            n++;
        end
        if (q.size() != 0) begin
            chk_cnt++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
            q.delete();
        end
        idle(2);
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    initial begin
        logic           rst_e, en_e, prev_ov;
        logic [2*W-1:0] prev_p;
        exp_t           it;
        prev_ov = 1'b0;
        prev_p  = '0;
        forever begin
            @(posedge clk);
            rst_e = rst;
            en_e  = en;
            #1;
            if (rst_e) begin
                chk("reset_state", {23'd0, out_valid, p}, 32'd0);
            end else if (en_e) begin
                en_edges++;
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk_cnt++;
                        $display("FAIL unexpected_product: got p=%h expected no out_valid", p);
                    end else begin
                        it = q.pop_front();
                        chk("product", {24'd0, p}, {24'd0, it.prod});
                        chk("latency", en_edges, it.due);
                    end
                end
            end else begin
                chk("stall_hold", {23'd0, out_valid, p}, {23'd0, prev_ov, prev_p});
            end
            prev_ov = out_valid;
            prev_p  = p;
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        // Reset
        rst = 1'b1;
        idle(2);
        @(negedge clk);
        rst = 1'b0;

        // Single op: 15*15, pulse then hold
        cyc(1'b1, 1'b1, 4'd15, 4'd15, 1'b0, 8'hE1);
        idle(8);
        chk("hold_after_pulse", {23'd0, out_valid, p}, {23'd0, 1'b0, 8'hE1});

        // Back-to-back stream
        cyc(1'b1, 1'b1, 4'd3,  4'd5,  1'b0, 8'h0F);
        cyc(1'b1, 1'b1, 4'd7,  4'd9,  1'b0, 8'h3F);
        cyc(1'b1, 1'b1, 4'd0,  4'd12, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 4'd15, 4'd1,  1'b0, 8'h0F);
        drain();

        // Stall: inputs presented while en=0 are ignored
        cyc(1'b1, 1'b1, 4'd6, 4'd7, 1'b0, 8'h2A);
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 4'd13, 4'd11, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 4'd14, 4'd2,  1'b0, 8'h00);
        cyc(1'b0, 1'b1, 4'd5,  4'd5,  1'b0, 8'h00);
        drain();

        // Reset mid-flight: 9*9 must never appear; in_valid during reset is dropped
        cyc(1'b1, 1'b1, 4'd9, 4'd9, 1'b0, 8'h51);
        cyc(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        q.delete();
        cyc(1'b0, 1'b1, 4'd4, 4'd4, 1'b0, 8'h10);
        @(negedge clk);
        rst = 1'b0;
        chk("post_reset", {23'd0, out_valid, p}, 32'd0);
        idle(7);
        cyc(1'b1, 1'b1, 4'd2, 4'd3, 1'b0, 8'h06);
        drain();

        // Random mixed valid/enable burst, checked against a*b
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rb, 1'b0,
                (2*W)'(ra) * (2*W)'(rb));
        end
        drain();

`ifdef SIGNED_MODE_EN
        // Signed and unsigned interleaved back-to-back
        cyc(1'b1, 1'b1, 4'd8, 4'd8, 1'b1, 8'h40);
        cyc(1'b1, 1'b1, 4'd8, 4'd7, 1'b1, 8'hC8);
        cyc(1'b1, 1'b1, 4'd8, 4'd7, 1'b0, 8'h38);
        cyc(1'b1, 1'b1, 4'd15, 4'd15, 1'b1, 8'h01);
        drain();
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
